// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO result registers.
//
// An accepted MULT/MULTU/DIV/DIVU latches its operands and holds busy high
// for a fixed number of cycles. The result is then written into HI/LO on
// the same edge where busy falls. MTHI/MTLO write one register directly
// from operand a, but only while the unit is idle.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request strobe
//   op       in   3-bit op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   a, b     in   WIDTH-bit operands (rs, rt)
//   busy     out  high while a multiply or divide is in flight
//   hi, lo   out  WIDTH-bit HI/LO registers
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // The counter is loaded with N-1 on the accepting edge. The result edge is
  // the one that sees zero, so busy is high for exactly N cycles.
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic             r_uns, w_uns_nxt;   // op[0] of the latched op: 1 = unsigned
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic             r_busy;

  // Results are formed only from the latched operands.
  logic        [2*WIDTH-1:0] w_prod_s;
  logic        [2*WIDTH-1:0] w_prod_u;
  logic        [2*WIDTH-1:0] w_ax_s, w_bx_s, w_ax_u, w_bx_u;
  logic                      w_div_zero;
  logic                      w_div_ovf;
  logic signed [WIDTH-1:0]   w_as, w_bs, w_qs, w_rs;
  logic        [WIDTH-1:0]   w_bu, w_qu, w_ru;

  assign w_ax_s   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_bx_s   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_ax_u   = {{WIDTH{1'b0}}, r_a};
  assign w_bx_u   = {{WIDTH{1'b0}}, r_b};
  // Sign-extending to 2*WIDTH before the multiply gives the exact signed product.
  assign w_prod_s = w_ax_s * w_bx_s;
  assign w_prod_u = w_ax_u * w_bx_u;

  assign w_div_zero = (r_b == '0);
  assign w_div_ovf  = (r_a == MIN) && (r_b == '1);

  // For MIN / -1 the divisor is replaced by 1. The quotient then comes out
  // as a and the remainder as 0, which is the required overflow result.
  // A zero divisor is also replaced by 1, only to keep the divider defined;
  // that result is overridden below.
  assign w_as = r_a;
  assign w_bs = (w_div_zero || w_div_ovf) ? ONE : r_b;
  assign w_qs = w_as / w_bs;
  assign w_rs = w_as % w_bs;
  assign w_bu = w_div_zero ? ONE : r_b;
  assign w_qu = r_a / w_bu;
  assign w_ru = r_a % w_bu;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_uns_nxt   = r_uns;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_a_nxt     = a;
              w_b_nxt     = b;
              w_uns_nxt   = op[0];
              w_cnt_nxt   = MUL_LOAD;
              w_state_nxt = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              w_a_nxt     = a;
              w_b_nxt     = b;
              w_uns_nxt   = op[0];
              w_cnt_nxt   = DIV_LOAD;
              w_state_nxt = S_DIV;
            end
            OP_MTHI: w_hi_nxt = a;
            OP_MTLO: w_lo_nxt = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_hi_nxt    = r_uns ? w_prod_u[2*WIDTH-1:WIDTH] : w_prod_s[2*WIDTH-1:WIDTH];
          w_lo_nxt    = r_uns ? w_prod_u[WIDTH-1:0]       : w_prod_s[WIDTH-1:0];
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          if (w_div_zero) begin
            w_lo_nxt = '1;
            w_hi_nxt = r_a;
          end else if (r_uns) begin
            w_lo_nxt = w_qu;
            w_hi_nxt = w_ru;
          end else begin
            w_lo_nxt = w_qs;
            w_hi_nxt = w_rs;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_uns   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_uns   <= w_uns_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;
  int c;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles with busy high, starting from the current cycle.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input int ecyc,
                     input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] old_hi, old_lo;
    int cyc;
    old_hi = hi;
    old_lo = lo;
    issue(o, x, y);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold_hi"}, hi, old_hi);
    check({tag, "_hold_lo"}, lo, old_lo);
    wait_idle(cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    a       = '0;
    b       = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    run("mult",    3'd0, 32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("multu",   3'd1, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE);
    run("div",     3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_z",  3'd3, 32'd7,         32'd0,         10, 32'd7,         32'hFFFF_FFFF);
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
    run("div_nb",  3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
    run("divu",    3'd3, 32'd100,       32'd7,         10, 32'd2,         32'd14);
    run("div_z",   3'd2, 32'hFFFF_FFF9, 32'd0,         10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI / MTLO in idle
    issue(3'd4, 32'h1234, 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'hFFFF_FFFF);
    issue(3'd5, 32'h55, 32'd0);
    check("mtlo_lo", lo, 32'h55);
    check("mtlo_hi", hi, 32'h1234);

    // reserved op ignored
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    check("rsv_busy", 32'(busy), 32'd0);
    check("rsv_hi", hi, 32'h1234);
    check("rsv_lo", lo, 32'h55);

    // MTLO attempted during a DIV is ignored
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    start = 1'b1; op = 3'd5; a = 32'hDEAD;
    tick();
    start = 1'b0;
    wait_idle(c);
    check("mtlo_busy_cyc", 32'(c), 32'd7);
    check("mtlo_busy_lo", lo, 32'd14);
    check("mtlo_busy_hi", hi, 32'd2);

    // operand changes and a DIV start during MULT have no effect
    issue(3'd0, 32'd3, 32'd5);
    a = 32'hFFFF; b = 32'hFFFF; start = 1'b1; op = 3'd2;
    tick();
    start = 1'b0; a = 32'd1; b = 32'd1;
    tick();
    tick();
    wait_idle(c);
    check("ign_cyc", 32'(c), 32'd2);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd15);
    tick();
    check("ign_nodiv", 32'(busy), 32'd0);

    // a start held through the completing edge is taken on the next edge
    issue(3'd0, 32'd2, 32'd3);
    start = 1'b1; op = 3'd4; a = 32'hAAAA;
    wait_idle(c);
    check("b2b_cyc", 32'(c), 32'd5);
    check("b2b_fall_hi", hi, 32'd0);
    check("b2b_fall_lo", lo, 32'd6);
    tick();
    start = 1'b0;
    check("b2b_next_hi", hi, 32'hAAAA);
    check("b2b_next_busy", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a DIV
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    start = 1'b1; op = 3'd5; a = 32'h77;
    tick();
    tick();
    check("arst_held_lo", lo, 32'd0);
    reset_n = 1'b1;
    tick();
    start = 1'b0;
    check("rel_accept_lo", lo, 32'h77);
    check("rel_accept_busy", 32'(busy), 32'd0);
    repeat (15) tick();
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'h77);
    check("abort_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
